// File: rtl/light_conflict_monitor.sv
// Safety stage behind the traffic light controller: registers the four light
// commands, rejects invalid encodings, conflicting greens and illegal colour
// sequences, and on any violation latches a fault and flashes all lamps red
// until an explicit clear is requested while every command is red.
module light_conflict_monitor #(
   parameter int MIN_YELLOW = 2,
   parameter int FLASH_HALF = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] light_M1_in,
   input  logic [2:0] light_S_in,
   input  logic [2:0] light_MT_in,
   input  logic [2:0] light_M2_in,
   input  logic       fault_clr,
   output logic [2:0] lamp_M1,
   output logic [2:0] lamp_S,
   output logic [2:0] lamp_MT,
   output logic [2:0] lamp_M2,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

   localparam int CW = (2 * FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;
   localparam int YW = $clog2(MIN_YELLOW + 1);
   localparam logic [CW-1:0] FLASH_LAST   = CW'(2 * FLASH_HALF - 1);
   localparam logic [CW-1:0] FLASH_HALF_C = CW'(FLASH_HALF);
   localparam logic [YW-1:0] MIN_YEL_C    = YW'(MIN_YELLOW);

   // Direction order everywhere: 0 = M1, 1 = S, 2 = MT, 3 = M2
   logic [2:0]    in_w      [4];
   logic [2:0]    lamp_q    [4];
   logic [2:0]    lamp_d    [4];
   logic [2:0]    prev_q    [4];
   logic [2:0]    prev_d    [4];
   logic [YW-1:0] yel_cnt_q [4];
   logic [YW-1:0] yel_cnt_d [4];

   logic          fault_q, fault_d;
   logic [2:0]    fault_code_q, fault_code_d;
   logic [CW-1:0] flash_cnt_q, flash_cnt_d;

   logic [3:0]    invalid_w;
   logic [3:0]    active_w;
   logic [3:0]    red_w;
   logic [3:0]    seq_bad_w;
   logic          conflict_w;
   logic [2:0]    cause_w;

   assign in_w[0] = light_M1_in;
   assign in_w[1] = light_S_in;
   assign in_w[2] = light_MT_in;
   assign in_w[3] = light_M2_in;

   // Per-direction encoding check, sequence check and history tracking.
   // History follows the raw inputs in every mode, so a clear resumes with
   // an accurate picture of what the controller is driving.
   for (genvar gi = 0; gi < 4; gi++) begin : g_dir
      assign invalid_w[gi] = !((in_w[gi] == RED) || (in_w[gi] == YEL) || (in_w[gi] == GRN));
      assign active_w[gi]  = (in_w[gi] != RED);
      assign red_w[gi]     = (in_w[gi] == RED);
      assign seq_bad_w[gi] = !((in_w[gi] == prev_q[gi]) ||
                               ((prev_q[gi] == RED) && (in_w[gi] == GRN)) ||
                               ((prev_q[gi] == GRN) && (in_w[gi] == YEL)) ||
                               ((prev_q[gi] == YEL) && (in_w[gi] == RED) &&
                                (yel_cnt_q[gi] >= MIN_YEL_C)));
      assign prev_d[gi]    = in_w[gi];
      assign yel_cnt_d[gi] = (in_w[gi] != YEL)            ? '0 :
                             (yel_cnt_q[gi] == MIN_YEL_C) ? yel_cnt_q[gi] :
                                                            yel_cnt_q[gi] + YW'(1);
   end

   // Side road may not run with any main movement; turn may not run with M2
   assign conflict_w = (active_w[1] && (active_w[0] || active_w[2] || active_w[3])) ||
                       (active_w[2] && active_w[3]);

   // Fault cause priority: invalid > conflict > sequence
   always_comb begin
      cause_w = 3'd0;
      if (|invalid_w) begin
         cause_w = 3'd1;
      end else if (conflict_w) begin
         cause_w = 3'd2;
      end else if (|seq_bad_w) begin
         cause_w = 3'd3;
      end
   end

   // Next-state for lamps, fault latch and flash counter
   always_comb begin
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      flash_cnt_d  = flash_cnt_q;
      for (int i = 0; i < 4; i++) begin
         lamp_d[i] = lamp_q[i];
      end
      if (!fault_q) begin
         if (cause_w != 3'd0) begin
            fault_d      = 1'b1;
            fault_code_d = cause_w;
            flash_cnt_d  = '0;
            for (int i = 0; i < 4; i++) begin
               lamp_d[i] = RED;
            end
         end else begin
            for (int i = 0; i < 4; i++) begin
               lamp_d[i] = in_w[i];
            end
         end
      end else if (fault_clr && (&red_w)) begin
         fault_d      = 1'b0;
         fault_code_d = 3'd0;
         flash_cnt_d  = '0;
         for (int i = 0; i < 4; i++) begin
            lamp_d[i] = RED;
         end
      end else begin
         flash_cnt_d = (flash_cnt_q == FLASH_LAST) ? '0 : flash_cnt_q + CW'(1);
         for (int i = 0; i < 4; i++) begin
            lamp_d[i] = (flash_cnt_d < FLASH_HALF_C) ? RED : OFF;
         end
      end
   end

   // State registers with synchronous reset to all-red, no fault
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q      <= 1'b0;
         fault_code_q <= 3'd0;
         flash_cnt_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            lamp_q[i]    <= RED;
            prev_q[i]    <= RED;
            yel_cnt_q[i] <= '0;
         end
      end else begin
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
         flash_cnt_q  <= flash_cnt_d;
         for (int i = 0; i < 4; i++) begin
            lamp_q[i]    <= lamp_d[i];
            prev_q[i]    <= prev_d[i];
            yel_cnt_q[i] <= yel_cnt_d[i];
         end
      end
   end

   assign lamp_M1    = lamp_q[0];
   assign lamp_S     = lamp_q[1];
   assign lamp_MT    = lamp_q[2];
   assign lamp_M2    = lamp_q[3];
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Bench for light_conflict_monitor: directed scenarios plus randomized
// traffic, checked against a rule-level model of the monitor.
module tb_light_conflict_monitor;

   localparam int MIN_YELLOW = 2;
   localparam int FLASH_HALF = 4;
   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] m1_in = RED, s_in = RED, mt_in = RED, m2_in = RED;
   logic       fault_clr = 1'b0;
   logic [2:0] lamp_M1, lamp_S, lamp_MT, lamp_M2;
   logic       fault;
   logic [2:0] fault_code;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   light_conflict_monitor #(.MIN_YELLOW(MIN_YELLOW), .FLASH_HALF(FLASH_HALF)) dut (
      .clk(clk), .rst(rst),
      .light_M1_in(m1_in), .light_S_in(s_in), .light_MT_in(mt_in), .light_M2_in(m2_in),
      .fault_clr(fault_clr),
      .lamp_M1(lamp_M1), .lamp_S(lamp_S), .lamp_MT(lamp_MT), .lamp_M2(lamp_M2),
      .fault(fault), .fault_code(fault_code)
   );

   wire [15:0] dut_vec = {lamp_M1, lamp_S, lamp_MT, lamp_M2, fault, fault_code};

   // Reference model: remembers the last command per direction, the full
   // length of the yellow run ending there, and how many cycles have passed
   // since the fault was raised (flash phase is derived from that count).
   logic [2:0] m_prev [4];
   int         m_run  [4];
   logic [2:0] m_lamp [4];
   bit         m_fault;
   int         m_code;
   int         m_since;

   function automatic bit is_legal_code(input logic [2:0] v);
      return (v == RED) || (v == YEL) || (v == GRN);
   endfunction

   function automatic bit transition_ok(input logic [2:0] p, input logic [2:0] c, input int run);
      if (p == c) return 1'b1;
      if (p == RED && c == GRN) return 1'b1;
      if (p == GRN && c == YEL) return 1'b1;
      if (p == YEL && c == RED && run >= MIN_YELLOW) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] model_vec();
      return {m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3], m_fault, 3'(m_code)};
   endfunction

   task automatic model_update(input logic [2:0] c [4], input bit clr, input bit r);
      int cause;
      bit any_invalid, any_seq, conflict, all_red;
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            m_prev[i] = RED; m_run[i] = 0; m_lamp[i] = RED;
         end
         m_fault = 0; m_code = 0; m_since = 0;
         return;
      end
      any_invalid = 0; any_seq = 0; all_red = 1;
      for (int i = 0; i < 4; i++) begin
         if (!is_legal_code(c[i])) any_invalid = 1;
         if (!transition_ok(m_prev[i], c[i], m_run[i])) any_seq = 1;
         if (c[i] != RED) all_red = 0;
      end
      conflict = (c[1] != RED && (c[0] != RED || c[2] != RED || c[3] != RED)) ||
                 (c[2] != RED && c[3] != RED);
      cause = any_invalid ? 1 : conflict ? 2 : any_seq ? 3 : 0;
      if (!m_fault) begin
         if (cause != 0) begin
            m_fault = 1; m_code = cause; m_since = 0;
            for (int i = 0; i < 4; i++) m_lamp[i] = RED;
         end else begin
            for (int i = 0; i < 4; i++) m_lamp[i] = c[i];
         end
      end else if (clr && all_red) begin
         m_fault = 0; m_code = 0; m_since = 0;
         for (int i = 0; i < 4; i++) m_lamp[i] = RED;
      end else begin
         m_since++;
         for (int i = 0; i < 4; i++)
            m_lamp[i] = ((m_since % (2 * FLASH_HALF)) < FLASH_HALF) ? RED : 3'b000;
      end
      for (int i = 0; i < 4; i++) begin
         m_run[i]  = (c[i] == YEL) ? m_run[i] + 1 : 0;
         m_prev[i] = c[i];
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, settle past it
   task automatic step(input logic [2:0] a, b, c, d, input logic clr, input logic r);
      logic [2:0] v [4];
      m1_in = a; s_in = b; mt_in = c; m2_in = d; fault_clr = clr; rst = r;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      @(posedge clk);
      model_update(v, clr, r);
      #1;
   endtask

   task automatic test_reset();
      step(GRN, RED, GRN, RED, 0, 1);
      step(RED, RED, RED, RED, 0, 1);
      checks++;
      if (dut_vec !== 16'h9240) begin
         errors++; $display("FAIL reset_state got=%h want=%h", dut_vec, 16'h9240);
      end
      step(RED, RED, RED, RED, 0, 0);
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++; $display("FAIL reset_idle got=%h want=%h", dut_vec, model_vec());
      end
      $display("test_reset done vec=%h", dut_vec);
   endtask

   task automatic test_pass_through();
      step(GRN, RED, GRN, RED, 0, 0);
      checks++;
      if (dut_vec !== {GRN, RED, GRN, RED, 1'b0, 3'd0}) begin
         errors++; $display("FAIL pass_through got=%h want=%h", dut_vec, {GRN, RED, GRN, RED, 1'b0, 3'd0});
      end
      step(GRN, RED, GRN, RED, 1, 0);
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++; $display("FAIL clr_no_fault got=%h want=%h", dut_vec, model_vec());
      end
      $display("test_pass_through done vec=%h", dut_vec);
   endtask

   task automatic test_conflict_flash();
      logic [11:0] want_l;
      step(RED, RED, RED, RED, 0, 1);
      step(GRN, RED, RED, RED, 0, 0);
      step(GRN, GRN, RED, RED, 0, 0);
      checks++;
      if (dut_vec !== {12'h924, 1'b1, 3'd2}) begin
         errors++; $display("FAIL conflict_entry got=%h want=%h", dut_vec, {12'h924, 1'b1, 3'd2});
      end
      for (int k = 1; k <= 16; k++) begin
         step(GRN, GRN, RED, RED, 0, 0);
         want_l = ((k % 8) < 4) ? 12'h924 : 12'h000;
         checks++;
         if (dut_vec !== {want_l, 1'b1, 3'd2} || lamp_S === GRN) begin
            errors++; $display("FAIL flash_k%0d got=%h want=%h", k, dut_vec, {want_l, 1'b1, 3'd2});
         end
      end
      $display("test_conflict_flash done vec=%h", dut_vec);
   endtask

   task automatic test_sequence();
      step(RED, RED, RED, RED, 0, 1);
      step(GRN, RED, RED, RED, 0, 0);
      step(YEL, RED, RED, RED, 0, 0);
      step(RED, RED, RED, RED, 0, 0);
      checks++;
      if (dut_vec !== {12'h924, 1'b1, 3'd3}) begin
         errors++; $display("FAIL short_yellow got=%h want=%h", dut_vec, {12'h924, 1'b1, 3'd3});
      end
      step(RED, RED, RED, RED, 0, 1);
      step(GRN, RED, RED, RED, 0, 0);
      step(YEL, RED, RED, RED, 0, 0);
      step(YEL, RED, RED, RED, 0, 0);
      step(RED, RED, RED, RED, 0, 0);
      checks++;
      if (dut_vec !== {12'h924, 1'b0, 3'd0}) begin
         errors++; $display("FAIL full_yellow got=%h want=%h", dut_vec, {12'h924, 1'b0, 3'd0});
      end
      step(YEL, RED, RED, RED, 0, 0);
      checks++;
      if (dut_vec !== {12'h924, 1'b1, 3'd3}) begin
         errors++; $display("FAIL red_to_yellow got=%h want=%h", dut_vec, {12'h924, 1'b1, 3'd3});
      end
      $display("test_sequence done vec=%h", dut_vec);
   endtask

   task automatic test_priority_and_clear();
      step(RED, RED, RED, RED, 0, 1);
      step(GRN, RED, RED, RED, 0, 0);
      step(GRN, GRN, 3'b011, RED, 0, 0);
      checks++;
      if (dut_vec !== {12'h924, 1'b1, 3'd1}) begin
         errors++; $display("FAIL invalid_priority got=%h want=%h", dut_vec, {12'h924, 1'b1, 3'd1});
      end
      step(RED, RED, RED, GRN, 1, 0);
      checks++;
      if (fault !== 1'b1 || fault_code !== 3'd1 || dut_vec !== model_vec()) begin
         errors++; $display("FAIL clr_not_red got=%h want=%h", dut_vec, model_vec());
      end
      step(RED, RED, RED, RED, 1, 0);
      checks++;
      if (dut_vec !== {12'h924, 1'b0, 3'd0}) begin
         errors++; $display("FAIL clear got=%h want=%h", dut_vec, {12'h924, 1'b0, 3'd0});
      end
      step(GRN, RED, RED, RED, 0, 0);
      checks++;
      if (dut_vec !== {GRN, RED, RED, RED, 1'b0, 3'd0}) begin
         errors++; $display("FAIL resume got=%h want=%h", dut_vec, {GRN, RED, RED, RED, 1'b0, 3'd0});
      end
      $display("test_priority_and_clear done vec=%h", dut_vec);
   endtask

   task automatic test_rst_mid_flash();
      step(RED, RED, RED, RED, 0, 1);
      step(RED, GRN, GRN, RED, 0, 0);
      for (int k = 0; k < 5; k++) step(RED, GRN, GRN, RED, 0, 0);
      step(RED, RED, RED, RED, 0, 1);
      checks++;
      if (dut_vec !== 16'h9240) begin
         errors++; $display("FAIL rst_mid_flash got=%h want=%h", dut_vec, 16'h9240);
      end
      for (int k = 0; k < 6; k++) step(RED, RED, RED, RED, 0, 0);
      checks++;
      if (dut_vec !== 16'h9240) begin
         errors++; $display("FAIL flash_stopped got=%h want=%h", dut_vec, 16'h9240);
      end
      $display("test_rst_mid_flash done vec=%h", dut_vec);
   endtask

   function automatic logic [2:0] advance(input logic [2:0] v);
      case (v)
         RED:     return GRN;
         GRN:     return YEL;
         YEL:     return RED;
         default: return RED;
      endcase
   endfunction

   task automatic test_random();
      logic [2:0] cur [4];
      logic       clr, r;
      int         rr;
      step(RED, RED, RED, RED, 0, 1);
      for (int i = 0; i < 4; i++) cur[i] = RED;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 4; i++) begin
            rr = $urandom_range(0, 99);
            if (rr >= 60 && rr < 93) cur[i] = advance(cur[i]);
            else if (rr >= 93) cur[i] = 3'($urandom_range(0, 7));
         end
         clr = ($urandom_range(0, 9) == 0);
         if (m_fault && $urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 4; i++) cur[i] = RED;
            clr = 1'b1;
         end
         r = ($urandom_range(0, 63) == 0);
         step(cur[0], cur[1], cur[2], cur[3], clr, r);
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL random_n%0d got=%h want=%h", n, dut_vec, model_vec());
         end
      end
      $display("test_random done vec=%h", dut_vec);
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_conflict_flash();
      test_sequence();
      test_priority_and_clear();
      test_rst_mid_flash();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
